nn_layer_sequencer: RTL and testbench

- FSM that drives the 4-input neuron-array shift register through one full inference: load 4 network inputs, run NUM_LAYERS layers of compute with feedback, then stream the 4 network outputs out.
- Generates the shift register's `selector` and `selector_output` codes, handshakes input data with the host, triggers the neuron array, and presents results with a valid/ready handshake.
- Sits between the host/top-level FSM, the shift register and the neuron array.

---
 rtl/nn_layer_sequencer.sv | 119 +++++++++++
 tb/tb_nn_layer_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/nn_layer_sequencer.sv
// nn_layer_sequencer: drives the neuron-array shift register through load, NUM_LAYERS compute layers and output streaming.
// Optional watchdog on neuron_done enabled by SEQ_WATCHDOG_EN.
module nn_layer_sequencer #(
  parameter int NUM_LAYERS  = 3,
  parameter int WDOG_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       neuron_start,
  input  logic       neuron_done,
  output logic [1:0] selector,
  output logic [1:0] selector_output,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] layer_idx,
  output logic       busy,
  output logic       done,
  output logic       err
);
  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, WAIT_N, FEEDBACK, OUT_SEL, OUT_PRES} state_t;
  localparam logic [3:0] LAST_LAYER = 4'(NUM_LAYERS - 1);
  state_t state, state_n;
  logic [1:0] load_cnt, load_cnt_n, out_idx, out_idx_n, sel_q;
  logic [3:0] layer_n;
  logic done_n;
`ifdef SEQ_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  logic [WW-1:0] wcnt;
  logic err_n;
`endif
  // the shift must land on the same edge that consumes data_in, so the hold code is overridden by the live handshake
  assign selector = (in_ready && in_valid) ? 2'b00 : sel_q;
  assign selector_output = out_idx;
  always_comb begin
    state_n = state;
    load_cnt_n = load_cnt;
    out_idx_n = out_idx;
    layer_n = layer_idx;
    done_n = 1'b0;
`ifdef SEQ_WATCHDOG_EN
    err_n = err;
`endif
    case (state)
      IDLE: if (start && !done) begin
        state_n = LOAD;
        load_cnt_n = 2'd0;
      end
      LOAD: if (in_valid) begin
        load_cnt_n = load_cnt + 2'd1;
        state_n = (load_cnt == 2'd3) ? COMPUTE : LOAD;
      end
      COMPUTE: state_n = WAIT_N;
      WAIT_N: if (neuron_done) state_n = FEEDBACK;
`ifdef SEQ_WATCHDOG_EN
      else if (wcnt == WW'(WDOG_CYCLES - 1)) begin
        state_n = IDLE;
        err_n = 1'b1;
        layer_n = 4'd0;
      end
`endif
      FEEDBACK: if (layer_idx == LAST_LAYER) begin
        state_n = OUT_SEL;
        out_idx_n = 2'd3;
      end else begin
        state_n = COMPUTE;
        layer_n = layer_idx + 4'd1;
      end
      OUT_SEL: state_n = OUT_PRES;
      OUT_PRES: if (out_ready) begin
        state_n = (out_idx == 2'd0) ? IDLE : OUT_SEL;
        done_n = (out_idx == 2'd0);
        layer_n = (out_idx == 2'd0) ? 4'd0 : layer_idx;
        out_idx_n = (out_idx == 2'd0) ? 2'd0 : out_idx - 2'd1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      load_cnt <= 2'd0;
      out_idx <= 2'd0;
      layer_idx <= 4'd0;
      sel_q <= 2'b01;
      in_ready <= 1'b0;
      neuron_start <= 1'b0;
      out_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      load_cnt <= load_cnt_n;
      out_idx <= out_idx_n;
      layer_idx <= layer_n;
      sel_q <= (state_n == FEEDBACK) ? 2'b10 : 2'b01;
      in_ready <= (state_n == LOAD);
      neuron_start <= (state_n == COMPUTE);
      out_valid <= (state_n == OUT_PRES);
      busy <= (state_n != IDLE);
      done <= done_n;
    end
  end
`ifdef SEQ_WATCHDOG_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wcnt <= '0;
      err <= 1'b0;
    end else begin
      wcnt <= (state == WAIT_N && state_n == WAIT_N) ? wcnt + 1'b1 : '0;
      err <= err_n;
    end
  end
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_nn_layer_sequencer.sv
// tb_nn_layer_sequencer: directed bench for nn_layer_sequencer (NUM_LAYERS=3, WDOG_CYCLES=10).
module tb_nn_layer_sequencer;
  logic clk = 1'b0, rstn, start, in_valid, neuron_done, out_ready;
  logic in_ready, neuron_start, out_valid, busy, done, err;
  logic [1:0] selector, selector_output;
  logic [3:0] layer_idx;
  int checks = 0, errors = 0;
  int n_sel00 = 0, n_sel10 = 0, n_start = 0, n_done = 0, n;
  logic count_en = 1'b0;

  nn_layer_sequencer #(.NUM_LAYERS(3), .WDOG_CYCLES(10)) dut (
    .clk(clk), .rstn(rstn), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .neuron_start(neuron_start), .neuron_done(neuron_done), .selector(selector),
    .selector_output(selector_output), .out_valid(out_valid), .out_ready(out_ready),
    .layer_idx(layer_idx), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // per-cycle event counters, sampled late in the low phase once inputs have settled
  always @(negedge clk) begin
    #4;
    if (count_en) begin
      n_sel00 += int'(selector == 2'b00);
      n_sel10 += int'(selector == 2'b10);
      n_start += int'(neuron_start);
      n_done += int'(done);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; in_valid = 1'b0; neuron_done = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_selector", selector, 1);
    check("rst_selout", selector_output, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_nstart", neuron_start, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_layer", layer_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    // reset in the middle of LOAD
    rstn = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1;
    #1;
    check("ld_in_ready", in_ready, 1);
    check("ld_busy", busy, 1);
    check("ld_sel_w1", selector, 0);
    @(negedge clk);
    #1;
    check("ld_sel_w2", selector, 0);
    @(negedge clk);
    in_valid = 1'b0; rstn = 1'b0;
    #1;
    check("ld_sel_hold", selector, 1);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("abort_selector", selector, 1);
    check("abort_in_ready", in_ready, 0);
    check("abort_busy", busy, 0);
    // full inference with gapped input handshake
    count_en = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = (i % 2 == 0);
      #1;
      check("gap_sel", selector, in_valid ? 0 : 1);
      check("gap_in_ready", in_ready, 1);
      @(negedge clk);
    end
    in_valid = 1'b1;
    #1;
    check("stray_valid_sel", selector, 1);
    check("compute_in_ready", in_ready, 0);
    check("sel00_count", n_sel00, 4);
    in_valid = 1'b0;
    for (int l = 0; l < 3; l++) begin
      neuron_done = (l == 0);
      #1;
      check("layer_nstart", neuron_start, 1);
      check("layer_idx", layer_idx, l);
      repeat (4) begin
        @(negedge clk);
        neuron_done = 1'b0;
      end
      @(negedge clk);
      neuron_done = 1'b1;
      #1;
      check("wait_nstart", neuron_start, 0);
      check("wait_sel", selector, 1);
      @(negedge clk);
      neuron_done = 1'b0;
      #1;
      check("fb_sel", selector, 2);
      check("fb_layer", layer_idx, l);
      @(negedge clk);
    end
    #1;
    check("nstart_count", n_start, 3);
    check("sel10_count", n_sel10, 3);
    check("osel_selout", selector_output, 3);
    check("osel_valid", out_valid, 0);
    check("osel_layer", layer_idx, 2);
    repeat (3) begin
      @(negedge clk);
      #1;
      check("stall_valid", out_valid, 1);
      check("stall_selout", selector_output, 3);
    end
    @(negedge clk);
    out_ready = 1'b1; start = 1'b1;
    #1;
    check("acc3_valid", out_valid, 1);
    check("acc3_selout", selector_output, 3);
    check("busy_start", busy, 1);
    for (int k = 2; k >= 0; k--) begin
      @(negedge clk);
      #1;
      check("osel_k_valid", out_valid, 0);
      check("osel_k_selout", selector_output, k);
      @(negedge clk);
      #1;
      check("opres_k_valid", out_valid, 1);
      check("opres_k_selout", selector_output, k);
    end
    @(negedge clk);
    #1;
    check("done_pulse", done, 1);
    check("done_busy", busy, 0);
    check("done_layer", layer_idx, 0);
    check("done_out_valid", out_valid, 0);
    @(negedge clk);
    #1;
    check("done_clear", done, 0);
    check("done_start_ignored", in_ready, 0);
    check("idle_busy", busy, 0);
    @(negedge clk);
    #1;
    check("restart_in_ready", in_ready, 1);
    check("restart_busy", busy, 1);
    check("done_count", n_done, 1);
    start = 1'b0; out_ready = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("rst2_busy", busy, 0);
    // neuron_done never arrives
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("wd_nstart", neuron_start, 1);
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
`ifdef SEQ_WATCHDOG_EN
    check("wd_cycles", n, 11);
    check("wd_err", err, 1);
    check("wd_selector", selector, 1);
    check("wd_no_done", n_done, 1);
    check("wd_layer", layer_idx, 0);
    repeat (3) @(negedge clk);
    #1;
    check("wd_err_sticky", err, 1);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("wd_err_cleared", err, 0);
`else
    check("nowd_still_busy", n, 40);
    check("nowd_err", err, 0);
    check("nowd_no_done", n_done, 1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
